radar_scan_ctrl: RTL
====================

# radar_scan_ctrl

Sequencer for the ultrasonic radar: steps a servo angle across a ping-pong sweep, fires one 10 µs trigger per angle, times the returning echo pulse with a timeout, and presents each (angle, echo count) result on a valid/ready port. It replaces free-running trigger generation and echo counting with one controlled measurement per angle. It sits between the sensor pins/servo driver and the display/host logic, clocked by the 1 µs system tick.

## Interface
- CNT_W, 18: width of all µs counters and of meas_count
- TRIG_US, 10: trigger pulse width, cycles
- SETTLE_US, 20000: servo settle + sensor holdoff before each trigger, cycles
- ECHO_TIMEOUT_US, 25000: max cycles from trigger fall to echo fall
- ANGLE_MIN, 0 / ANGLE_MAX, 180 / ANGLE_STEP, 15: sweep limits in degrees; (ANGLE_MAX−ANGLE_MIN) is a multiple of ANGLE_STEP
- clk  in  1  1 MHz clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  level; 1 = keep scanning, 0 = stop after current measurement
- echo  in  1  raw sensor echo, asynchronous
- trig  out  1  sensor trigger
- angle  out  8  servo command, degrees
- busy  out  1  1 in any state except IDLE
- meas_valid  out  1  result available
- meas_ready  in  1  consumer accepts result
- meas_angle  out  8  angle of this result
- meas_count  out  CNT_W  echo high time in cycles
- meas_timeout  out  1  result is a timeout

## Operation
- States: IDLE, SETTLE, TRIG, WAIT_RISE, MEASURE, REPORT.
- IDLE: start=1 → SETTLE, counter cleared. angle holds its last value.
- SETTLE: count SETTLE_US cycles → TRIG.
- TRIG: trig=1 for exactly TRIG_US cycles → WAIT_RISE; timeout counter cleared.
- WAIT_RISE: wait for a synchronized echo 0→1 edge; echo already high on entry is ignored until it falls and rises again. Edge → MEASURE, echo counter = 1.
- MEASURE: echo counter +1 per cycle while synchronized echo=1; falling edge → REPORT with meas_count = counter, meas_timeout=0.
- Timeout counter runs through WAIT_RISE and MEASURE; reaching ECHO_TIMEOUT_US → REPORT with meas_count = ECHO_TIMEOUT_US, meas_timeout=1. Timeout and echo fall in the same cycle: echo fall wins.
- meas_count saturates at all-ones, never wraps.
- REPORT: meas_valid=1; meas_angle/count/timeout stable until meas_ready=1 is sampled. On accept: step angle, then start=1 → SETTLE, start=0 → IDLE.
- Angle step: direction register, up after reset. Up: angle==ANGLE_MAX → dir=down, angle−=STEP; else angle+=STEP. Down mirrors at ANGLE_MIN. Endpoints visited once per reversal.
- start falling mid-measurement does not abort; the measurement completes and reports.
- Echo synchronizer: two flops plus one edge-detect register; meas_count is unaffected by synchronizer latency (both edges delayed equally).

## Timing
- Reset values: trig=0, angle=ANGLE_MIN, dir=up, busy=0, meas_valid=0, meas_angle=0, meas_count=0, meas_timeout=0, state IDLE, synchronizer flops 0.
- rst_n=0 in any state, including mid-trigger or mid-REPORT: next edge returns to reset values; a pending result is dropped.
- start sampled in IDLE → trig rises SETTLE_US+1 cycles later.
- Echo pin edge → state change 3 cycles later.
- meas_valid rises the cycle after the decisive echo-fall/timeout; falls the cycle after accept; same-cycle accept is accepted.
- No combinational path from any input to any output.

## Structure
- Package radar_pkg: state enum, angle width 8, default timing constants (TRIG_US, SETTLE_US, ECHO_TIMEOUT_US), shared with future radar blocks.
- One sub-module: radar_echo_sync (2-flop synchronizer + rise/fall pulse outputs).
- Everything else (FSM, three counters, angle stepper) in radar_scan_ctrl.

## Test plan
Bench parameters: SETTLE_US=5, TRIG_US=10, ECHO_TIMEOUT_US=100, ANGLE_STEP=60, ANGLE_MAX=180.
- Reset, start=1, echo high 40 cycles after trig fall → trig high exactly 10 cycles; meas_angle=0, meas_count=40, meas_timeout=0; angle→60.
- Echo never rises → meas_timeout=1, meas_count=100, at timeout+1 cycle.
- meas_ready held 0 for 20 cycles in REPORT → meas_valid and data stable throughout; no next trig until accept.
- Continuous scan with ready=1 → meas_angle sequence 0,60,120,180,120,60,0,60.
- start dropped during MEASURE → result still reported, then IDLE, busy=0, no further trig.
- rst_n pulsed low during TRIG and during REPORT → trig=0, meas_valid=0, angle=0 next edge; echo high at reset release is ignored until a fresh rising edge.

Source files
------------

// File: rtl/radar_pkg.sv
// Shared definitions for the ultrasonic radar blocks: sequencer states and
// default timing constants, all expressed in 1 us system ticks.
package radar_pkg;

    localparam int ANGLE_W             = 8;
    localparam int CNT_W_DEF           = 18;
    localparam int TRIG_US_DEF         = 10;
    localparam int SETTLE_US_DEF       = 20000;
    localparam int ECHO_TIMEOUT_US_DEF = 25000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_REPORT
    } radar_state_e;

endpackage

// File: rtl/radar_echo_sync.sv
// Two-flop synchronizer for the asynchronous echo pin plus an edge-detect
// register producing single-cycle rise/fall pulses from the synchronized level.
module radar_echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic echo_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/radar_scan_ctrl.sv
// Ultrasonic radar sequencer: ping-pong servo sweep, one trigger per angle,
// echo pulse timing with timeout, result handed out on a valid/ready port.
//
//   state     | meaning
//   IDLE      | not scanning, angle held
//   SETTLE    | servo settle / sensor holdoff
//   TRIG      | trigger pulse high
//   WAIT_RISE | waiting for a fresh echo rising edge
//   MEASURE   | counting echo high time
//   REPORT    | result valid, waiting for meas_ready
module radar_scan_ctrl
    import radar_pkg::*;
#(
    parameter int CNT_W           = CNT_W_DEF,
    parameter int TRIG_US         = TRIG_US_DEF,
    parameter int SETTLE_US       = SETTLE_US_DEF,
    parameter int ECHO_TIMEOUT_US = ECHO_TIMEOUT_US_DEF,
    parameter int ANGLE_MIN       = 0,
    parameter int ANGLE_MAX       = 180,
    parameter int ANGLE_STEP      = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               echo,
    output logic               trig,
    output logic [ANGLE_W-1:0] angle,
    output logic               busy,
    output logic               meas_valid,
    input  logic               meas_ready,
    output logic [ANGLE_W-1:0] meas_angle,
    output logic [CNT_W-1:0]   meas_count,
    output logic               meas_timeout
);

    localparam logic [ANGLE_W-1:0] A_MIN  = ANGLE_W'(ANGLE_MIN);
    localparam logic [ANGLE_W-1:0] A_MAX  = ANGLE_W'(ANGLE_MAX);
    localparam logic [ANGLE_W-1:0] A_STEP = ANGLE_W'(ANGLE_STEP);

    radar_state_e       state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   echo_cnt_q, echo_cnt_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               dir_up_q, dir_up_d;
    logic [ANGLE_W-1:0] m_angle_q, m_angle_d;
    logic [CNT_W-1:0]   m_count_q, m_count_d;
    logic               m_tmo_q, m_tmo_d;

    logic echo_lvl, echo_rise, echo_fall;

    radar_echo_sync u_echo_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .echo_i  (echo),
        .level_o (echo_lvl),
        .rise_o  (echo_rise),
        .fall_o  (echo_fall)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tmo_d      = tmo_q;
        echo_cnt_d = echo_cnt_q;
        angle_d    = angle_q;
        dir_up_d   = dir_up_q;
        m_angle_d  = m_angle_q;
        m_count_d  = m_count_q;
        m_tmo_d    = m_tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    timer_d = CNT_W'(SETTLE_US);
                end
            end
            S_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = S_TRIG;
                    timer_d = CNT_W'(TRIG_US - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_TRIG: begin
                if (timer_q == '0) begin
                    state_d = S_WAIT_RISE;
                    tmo_d   = CNT_W'(ECHO_TIMEOUT_US - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_WAIT_RISE: begin
                if (tmo_q == '0) begin
                    state_d   = S_REPORT;
                    m_angle_d = angle_q;
                    m_count_d = CNT_W'(ECHO_TIMEOUT_US);
                    m_tmo_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                    if (echo_rise) begin
                        state_d    = S_MEASURE;
                        echo_cnt_d = CNT_W'(1);
                    end
                end
            end
            S_MEASURE: begin
                // echo fall takes priority over a coincident timeout
                if (echo_fall) begin
                    state_d   = S_REPORT;
                    m_angle_d = angle_q;
                    m_count_d = echo_cnt_q;
                    m_tmo_d   = 1'b0;
                end else if (tmo_q == '0) begin
                    state_d   = S_REPORT;
                    m_angle_d = angle_q;
                    m_count_d = CNT_W'(ECHO_TIMEOUT_US);
                    m_tmo_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                    if (echo_lvl && (echo_cnt_q != '1)) begin
                        echo_cnt_d = echo_cnt_q + 1'b1;
                    end
                end
            end
            S_REPORT: begin
                if (meas_ready) begin
                    if (dir_up_q) begin
                        if (angle_q == A_MAX) begin
                            dir_up_d = 1'b0;
                            angle_d  = angle_q - A_STEP;
                        end else begin
                            angle_d = angle_q + A_STEP;
                        end
                    end else begin
                        if (angle_q == A_MIN) begin
                            dir_up_d = 1'b1;
                            angle_d  = angle_q + A_STEP;
                        end else begin
                            angle_d = angle_q - A_STEP;
                        end
                    end
                    if (start) begin
                        state_d = S_SETTLE;
                        timer_d = CNT_W'(SETTLE_US);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            tmo_q      <= '0;
            echo_cnt_q <= '0;
            angle_q    <= A_MIN;
            dir_up_q   <= 1'b1;
            m_angle_q  <= '0;
            m_count_q  <= '0;
            m_tmo_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            tmo_q      <= tmo_d;
            echo_cnt_q <= echo_cnt_d;
            angle_q    <= angle_d;
            dir_up_q   <= dir_up_d;
            m_angle_q  <= m_angle_d;
            m_count_q  <= m_count_d;
            m_tmo_q    <= m_tmo_d;
        end
    end

    assign trig         = (state_q == S_TRIG);
    assign busy         = (state_q != S_IDLE);
    assign meas_valid   = (state_q == S_REPORT);
    assign angle        = angle_q;
    assign meas_angle   = m_angle_q;
    assign meas_count   = m_count_q;
    assign meas_timeout = m_tmo_q;

endmodule
